// File: rtl/pwm_fade.sv
// Triangular "breathing" duty generator for the PWM stage: ramps up, dwells, ramps down, dwells.
// Latency: a prescaler tick in cycle N is visible on duty/phase/strobes in cycle N+1.
// Backpressure: none; en=0 freezes every register, and a pending strobe still drops after one cycle.
// Build option PWM_FADE_GAMMA_EN: duty is the upper R bits of level_next squared (perceptual curve).
module pwm_fade #(
    parameter int R       = 10,
    parameter int PRESC_W = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [R-1:0]       step,
    input  logic [PRESC_W-1:0] tick_div,
    input  logic [7:0]         hold,
    output logic [R-1:0]       duty,
    output logic [1:0]         phase,
    output logic               top_pulse,
    output logic               bot_pulse
);

    typedef enum logic [1:0] {
        UP      = 2'd0,
        HOLD_HI = 2'd1,
        DOWN    = 2'd2,
        HOLD_LO = 2'd3
    } state_t;

    localparam logic [R-1:0]       MAX   = '1;
    localparam logic [R-1:0]       L_ONE = 1;
    localparam logic [PRESC_W-1:0] P_ONE = 1;
    localparam logic [7:0]         H_ONE = 1;

    state_t             state;
    logic [R-1:0]       level;
    logic [7:0]         hcnt;
    logic [PRESC_W-1:0] pcnt;
    logic               tick;
    logic [R-1:0]       seff;
    logic               at_top;
    logic               at_bot;
    logic [R-1:0]       level_next;
    logic [R-1:0]       duty_d;

    // ">=" rather than "==" so lowering tick_div below pcnt fires immediately instead of wrapping
    assign tick   = en && (pcnt >= tick_div);
    assign seff   = (step == '0) ? L_ONE : step;
    // Headroom compares: MAX-level and level never underflow, so no wider arithmetic is needed
    assign at_top = (seff >= (MAX - level));
    assign at_bot = (level <= seff);
    assign phase  = state;

    // Prescaler: free-running update-rate divider, frozen while en is low
    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (en) begin
            if (tick) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + P_ONE;
            end
        end
    end

    // Next level, saturating at both ends; also feeds the duty register so duty tracks level
    always_comb begin
        level_next = level;
        if (tick) begin
            case (state)
                UP:      level_next = at_top ? MAX : (level + seff);
                DOWN:    level_next = at_bot ? '0 : (level - seff);
                default: level_next = level;
            endcase
        end
    end

`ifdef PWM_FADE_GAMMA_EN
    logic [2*R-1:0] level_sq;
    assign level_sq = {{R{1'b0}}, level_next} * {{R{1'b0}}, level_next};
    assign duty_d   = level_sq[2*R-1:R];
`else
    assign duty_d   = level_next;
`endif

    // Ramp/dwell state machine with single-cycle strobes on entering each hold
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HOLD_LO;
            level     <= '0;
            hcnt      <= '0;
            top_pulse <= 1'b0;
            bot_pulse <= 1'b0;
        end else begin
            top_pulse <= 1'b0;
            bot_pulse <= 1'b0;
            level     <= level_next;
            if (tick) begin
                case (state)
                    UP: begin
                        if (at_top) begin
                            state     <= HOLD_HI;
                            hcnt      <= '0;
                            top_pulse <= 1'b1;
                        end
                    end
                    HOLD_HI: begin
                        if (hcnt == hold) begin
                            state <= DOWN;
                        end else begin
                            hcnt <= hcnt + H_ONE;
                        end
                    end
                    DOWN: begin
                        if (at_bot) begin
                            state     <= HOLD_LO;
                            hcnt      <= '0;
                            bot_pulse <= 1'b1;
                        end
                    end
                    default: begin
                        if (hcnt == hold) begin
                            state <= UP;
                        end else begin
                            hcnt <= hcnt + H_ONE;
                        end
                    end
                endcase
            end
        end
    end

    // Duty output register, loaded on the same edge as level
    always_ff @(posedge clk) begin
        if (reset) begin
            duty <= '0;
        end else begin
            duty <= duty_d;
        end
    end

endmodule

// File: tb/tb_pwm_fade.sv
// Bench for pwm_fade: behavioural reference model feeds an expected-value queue every clock,
// and directed scenarios add fixed-value checks taken from known ramp sequences.
// All inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_pwm_fade;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [9:0]  step;
    logic [19:0] tick_div;
    logic [7:0]  hold;
    logic [9:0]  duty;
    logic [1:0]  phase;
    logic        top_pulse;
    logic        bot_pulse;

    pwm_fade #(.R(10), .PRESC_W(20)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .step      (step),
        .tick_div  (tick_div),
        .hold      (hold),
        .duty      (duty),
        .phase     (phase),
        .top_pulse (top_pulse),
        .bot_pulse (bot_pulse)
    );

    always #5 clk = ~clk;

    int    n_run  = 0;
    int    n_fail = 0;
    string cur    = "none";

    typedef struct packed {
        logic [9:0] duty;
        logic [1:0] phase;
        logic       top;
        logic       bot;
    } obs_t;

    obs_t exp_q[$];

    // Reference model state (plain integers, full-range arithmetic then clamped)
    int m_pcnt, m_level, m_phase, m_hcnt, m_duty, m_top, m_bot;

    function automatic int dmap(input int x);
`ifdef PWM_FADE_GAMMA_EN
        return (x * x) / 1024;
`else
        return x;
`endif
    endfunction

    task automatic model_eval();
        int s;
        int tk;
        if (reset) begin
            m_pcnt = 0; m_level = 0; m_phase = 3; m_hcnt = 0; m_top = 0; m_bot = 0;
        end else begin
            m_top = 0;
            m_bot = 0;
            if (en) begin
                tk = (m_pcnt >= int'(tick_div)) ? 1 : 0;
                m_pcnt = tk ? 0 : m_pcnt + 1;
                if (tk != 0) begin
                    s = (step == 0) ? 1 : int'(step);
                    if (m_phase == 0) begin
                        if (m_level + s >= 1023) begin
                            m_level = 1023; m_phase = 1; m_hcnt = 0; m_top = 1;
                        end else m_level = m_level + s;
                    end else if (m_phase == 2) begin
                        if (m_level - s <= 0) begin
                            m_level = 0; m_phase = 3; m_hcnt = 0; m_bot = 1;
                        end else m_level = m_level - s;
                    end else begin
                        if (m_hcnt == int'(hold)) m_phase = (m_phase == 1) ? 2 : 0;
                        else m_hcnt = m_hcnt + 1;
                    end
                end
            end
        end
        m_duty = dmap(m_level);
    endtask

    // One clock: predict, push, advance, pop and compare
    task automatic cycle();
        obs_t e;
        model_eval();
        e.duty = m_duty[9:0]; e.phase = m_phase[1:0]; e.top = m_top[0]; e.bot = m_bot[0];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_run++;
        if (duty !== e.duty || phase !== e.phase || top_pulse !== e.top || bot_pulse !== e.bot) begin
            n_fail++;
            $display("FAIL sb_%s: got duty=%0d phase=%0d top=%0b bot=%0b, want duty=%0d phase=%0d top=%0b bot=%0b",
                     cur, duty, phase, top_pulse, bot_pulse, e.duty, e.phase, e.top, e.bot);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; en = 1'b0;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        cur = "reset";
        step = 10'd5; tick_div = 20'd0; hold = 8'd0;
        reset = 1'b1; en = 1'b1;
        cycle();
        cycle();
        n_run++;
        if (duty !== 10'd0 || phase !== 2'd3 || top_pulse !== 1'b0 || bot_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: got duty=%0d phase=%0d top=%0b bot=%0b, want 0 3 0 0",
                     duty, phase, top_pulse, bot_pulse);
        end
        reset = 1'b0;
    endtask

    task automatic test_linear_ramp();
        int exp_d[10] = '{0, 256, 512, 768, 1023, 1023, 767, 511, 255, 0};
        int exp_p[10] = '{0, 0, 0, 0, 1, 2, 2, 2, 2, 3};
        cur = "linear";
        do_reset();
        step = 10'd256; tick_div = 20'd0; hold = 8'd0; en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_run++;
            if (int'(duty) != dmap(exp_d[i]) || int'(phase) != exp_p[i] ||
                top_pulse !== (i == 4) || bot_pulse !== (i == 9)) begin
                n_fail++;
                $display("FAIL linear_seq[%0d]: got duty=%0d phase=%0d top=%0b bot=%0b, want duty=%0d phase=%0d top=%0b bot=%0b",
                         i, duty, phase, top_pulse, bot_pulse, dmap(exp_d[i]), exp_p[i], (i == 4), (i == 9));
            end
        end
    endtask

    task automatic test_prescaler_dwell();
        int top_at, bot_at, hi_cnt, changes;
        logic [9:0] prev;
        cur = "presc";
        do_reset();
        step = 10'd1023; tick_div = 20'd4; hold = 8'd2; en = 1'b1;
        top_at = -1; bot_at = -1; hi_cnt = 0; changes = 0; prev = duty;
        for (int i = 1; i <= 45; i++) begin
            cycle();
            if (top_pulse) top_at = i;
            if (bot_pulse) bot_at = i;
            if (phase == 2'd1) hi_cnt++;
            if (duty != prev && (i % 5) != 0) changes++;
            prev = duty;
        end
        n_run++;
        if (top_at != 20 || bot_at != 40) begin
            n_fail++;
            $display("FAIL presc_strobes: got top at %0d bot at %0d, want 20 and 40", top_at, bot_at);
        end
        n_run++;
        if (hi_cnt != 15) begin
            n_fail++;
            $display("FAIL presc_hold_len: got %0d clocks in HOLD_HI, want 15", hi_cnt);
        end
        n_run++;
        if (changes != 0) begin
            n_fail++;
            $display("FAIL presc_offtick_change: got %0d duty changes off the tick grid, want 0", changes);
        end
    endtask

    task automatic test_step_zero_sat();
        cur = "stepsat";
        do_reset();
        step = 10'd0; tick_div = 20'd0; hold = 8'd0; en = 1'b1;
        cycle();
        cycle();
        n_run++;
        if (int'(duty) != dmap(1)) begin
            n_fail++;
            $display("FAIL step0_first: got duty=%0d, want %0d", duty, dmap(1));
        end
        cycle();
        n_run++;
        if (int'(duty) != dmap(2)) begin
            n_fail++;
            $display("FAIL step0_second: got duty=%0d, want %0d", duty, dmap(2));
        end
        step = 10'd98;
        cycle();
        step = 10'd1000;
        cycle();
        n_run++;
        if (int'(duty) != dmap(1023) || top_pulse !== 1'b1 || phase !== 2'd1) begin
            n_fail++;
            $display("FAIL saturate_top: got duty=%0d top=%0b phase=%0d, want duty=%0d top=1 phase=1",
                     duty, top_pulse, phase, dmap(1023));
        end
    endtask

    task automatic test_freeze_reset();
        int bad;
        cur = "freeze";
        do_reset();
        step = 10'd256; tick_div = 20'd0; hold = 8'd0; en = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        n_run++;
        if (int'(duty) != dmap(512)) begin
            n_fail++;
            $display("FAIL freeze_pre: got duty=%0d, want %0d", duty, dmap(512));
        end
        en = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cycle();
            if (int'(duty) != dmap(512) || phase !== 2'd0) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL freeze_hold: got %0d cycles off duty=%0d phase=0, want 0", bad, dmap(512));
        end
        en = 1'b1;
        cycle();
        n_run++;
        if (int'(duty) != dmap(768)) begin
            n_fail++;
            $display("FAIL freeze_resume: got duty=%0d, want %0d", duty, dmap(768));
        end
        cycle();
        en = 1'b0;
        cycle();
        n_run++;
        if (top_pulse !== 1'b0 || int'(duty) != dmap(1023) || phase !== 2'd1) begin
            n_fail++;
            $display("FAIL freeze_strobe: got top=%0b duty=%0d phase=%0d, want top=0 duty=%0d phase=1",
                     top_pulse, duty, phase, dmap(1023));
        end
        en = 1'b1;
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        n_run++;
        if (duty !== 10'd0 || phase !== 2'd3) begin
            n_fail++;
            $display("FAIL reset_mid_down: got duty=%0d phase=%0d, want 0 3", duty, phase);
        end
        reset = 1'b0;
    endtask

    task automatic test_tick_div_change();
        int first, second;
        logic [9:0] prev;
        cur = "tdchg";
        do_reset();
        step = 10'd1; tick_div = 20'd100; hold = 8'd0; en = 1'b1;
        for (int i = 0; i < 50; i++) cycle();
        tick_div = 20'd10;
        cycle();
        n_run++;
        if (phase !== 2'd0) begin
            n_fail++;
            $display("FAIL tdchg_immediate: got phase=%0d, want 0", phase);
        end
        first = -1; second = -1; prev = duty;
        for (int i = 1; i <= 22; i++) begin
            cycle();
            if (duty != prev) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
            prev = duty;
        end
        n_run++;
        if (first != 11 || second != 22) begin
            n_fail++;
            $display("FAIL tdchg_period: got changes at %0d and %0d, want 11 and 22", first, second);
        end
    endtask

    task automatic test_back_to_back();
        int r;
        cur = "random";
        do_reset();
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 3);
            step = (r == 0) ? 10'd0 : (r == 1) ? 10'd1023 :
                   (r == 2) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(1, 40));
            if ($urandom_range(0, 7) == 0) tick_div = 20'($urandom_range(0, 3));
            hold  = 8'($urandom_range(0, 3));
            en    = ($urandom_range(0, 4) != 0);
            reset = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; step = '0; tick_div = '0; hold = '0;
        test_reset();
        test_linear_ramp();
        test_prescaler_dwell();
        test_step_zero_sat();
        test_freeze_reset();
        test_tick_div_change();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
